// File: rtl/gpu_mem_pkg.sv
// Shared types and address helpers for the banked scratchpad.
package gpu_mem_pkg;

  localparam int unsigned CNT_WIDTH_DEF  = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned DATA_WIDTH_DEF = 8;

  // One port's request payload at the default geometry.
  typedef struct packed {
    logic                      write;
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] wdata;
  } mem_req_t;

  // Bank select: low-order address bits (num_banks is a power of 2).
  function automatic int unsigned bank_of(input int unsigned addr, input int unsigned num_banks);
    return addr % num_banks;
  endfunction

  // Row within the bank: remaining high-order address bits.
  function automatic int unsigned row_of(input int unsigned addr, input int unsigned num_banks);
    return addr / num_banks;
  endfunction

endpackage

// File: rtl/bank_rr_arbiter.sv
// Round-robin arbiter for one bank: one-hot winner, pointer advances past each winner.
module bank_rr_arbiter #(
  parameter int unsigned NUM_PORTS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] winner_c
);

  localparam int unsigned PW = $clog2(NUM_PORTS);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic          found;
  int unsigned   idx;

  // Pick the first requester at or after ptr in circular order.
  always_comb begin
    winner_c = '0;
    ptr_next = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && req[PW'(idx)]) begin
        found              = 1'b1;
        winner_c[PW'(idx)] = 1'b1;
        ptr_next           = (idx == NUM_PORTS - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  // Pointer only moves when the bank granted something.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr <= '0;
    else          ptr <= ptr_next;
  end

endmodule

// File: rtl/banked_shared_memory.sv
// Multi-port banked scratchpad with per-bank round-robin and read broadcast.
module banked_shared_memory
  import gpu_mem_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_PORTS-1:0]                  req_valid,
  input  logic [NUM_PORTS-1:0]                  req_write,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]                  req_ready,
  output logic [NUM_PORTS-1:0]                  rsp_valid,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rsp_rdata,
  output logic [CNT_WIDTH-1:0]                  read_count,
  output logic [CNT_WIDTH-1:0]                  write_count,
  output logic [CNT_WIDTH-1:0]                  conflict_count
);

  localparam int unsigned ROWS   = (2 ** ADDR_WIDTH) / NUM_BANKS;
  localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [BANK_W-1:0]                   bank_idx [NUM_PORTS];
  logic [ROW_W-1:0]                    row_idx  [NUM_PORTS];
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0] bank_req;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0] bank_win;
  logic [NUM_PORTS-1:0]                grant;
  logic [NUM_PORTS-1:0]                rd_grant;
  logic [NUM_PORTS-1:0]                wr_grant;
  logic                                win_read;
  logic [ADDR_WIDTH-1:0]               win_addr;

  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][ROWS];

  // Split each port address into bank and row, and build per-bank request masks.
  always_comb begin
    bank_req = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      bank_idx[p] = BANK_W'(bank_of(32'(req_addr[p]), NUM_BANKS));
      row_idx[p]  = ROW_W'(row_of(32'(req_addr[p]), NUM_BANKS));
    end
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        bank_req[b][p] = req_valid[p] && (bank_idx[p] == BANK_W'(b));
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    bank_rr_arbiter #(
      .NUM_PORTS (NUM_PORTS)
    ) u_arb (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (bank_req[b]),
      .winner_c (bank_win[b])
    );
  end

  // Grant each bank's winner, plus any read sharing a read winner's exact address.
  always_comb begin
    grant    = '0;
    win_read = 1'b0;
    win_addr = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      win_read = 1'b0;
      win_addr = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (bank_win[b][p]) begin
          win_read = !req_write[p];
          win_addr = req_addr[p];
        end
      end
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (bank_req[b][p] &&
            (bank_win[b][p] || (win_read && !req_write[p] && (req_addr[p] == win_addr)))) begin
          grant[p] = 1'b1;
        end
      end
    end
  end

  assign req_ready = grant;
  assign rd_grant  = grant & ~req_write;
  assign wr_grant  = grant & req_write;

  // Storage update; at most one write per bank per cycle by construction.
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (wr_grant[p]) mem[bank_idx[p]][row_idx[p]] <= req_wdata[p];
    end
  end

  // Read responses one cycle after grant, and performance counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid      <= '0;
      rsp_rdata      <= '0;
      read_count     <= '0;
      write_count    <= '0;
      conflict_count <= '0;
    end else begin
      rsp_valid <= rd_grant;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (rd_grant[p]) rsp_rdata[p] <= mem[bank_idx[p]][row_idx[p]];
      end
      read_count  <= read_count + CNT_WIDTH'($countones(rd_grant));
      write_count <= write_count + CNT_WIDTH'($countones(wr_grant));
      if (|(req_valid & ~grant)) conflict_count <= conflict_count + CNT_WIDTH'(1);
    end
  end

endmodule
